// File: rtl/clk_rst_seq.sv
// clk_rst_seq: DCM reset/lock sequencer with lock-timeout retry
// and staged, ordered release of three downstream resets.
module clk_rst_seq #(
  parameter int RST_CYCLES   = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STAGE_DELAY  = 16,
  parameter int MAX_RETRY    = 4
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       swRst,
  input  logic       dcmLocked,
  output logic       dcmRst,
  output logic [2:0] rstOut,
  output logic       ready,
  output logic [3:0] retryCnt,
  output logic       lockErr
);

  localparam int M0   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC = (M0 > STAGE_DELAY) ? M0 : STAGE_DELAY;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STG_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [3:0]    MAXR     = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_DCMRST,
    S_WAIT,
    S_REL,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    stg_q;
  logic          s1_q, s2_q;
  logic          dcmRst_q, ready_q, lockErr_q;
  logic [2:0]    rstOut_q;
  logic [3:0]    retry_q, retry_d;
  logic          lockS;

  assign lockS = s2_q;

  always_comb begin
    retry_d = retry_q;
    if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= dcmLocked;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_DCMRST;
      cnt_q     <= '0;
      stg_q     <= 2'd0;
      dcmRst_q  <= 1'b1;
      rstOut_q  <= 3'b111;
      ready_q   <= 1'b0;
      retry_q   <= 4'd0;
      lockErr_q <= 1'b0;
    end else if (swRst) begin
      state_q   <= S_DCMRST;
      cnt_q     <= '0;
      stg_q     <= 2'd0;
      dcmRst_q  <= 1'b1;
      rstOut_q  <= 3'b111;
      ready_q   <= 1'b0;
      retry_q   <= 4'd0;
      lockErr_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_DCMRST: begin
          if (cnt_q == RST_LAST) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            dcmRst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          // Lock wins over a coincident timeout
          if (lockS) begin
            state_q <= S_REL;
            cnt_q   <= '0;
            stg_q   <= 2'd0;
          end else if (cnt_q == TO_LAST) begin
            retry_q  <= retry_d;
            cnt_q    <= '0;
            dcmRst_q <= 1'b1;
            if (retry_d >= MAXR) begin
              state_q   <= S_FAIL;
              lockErr_q <= 1'b1;
            end else begin
              state_q <= S_DCMRST;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_REL: begin
          if (!lockS) begin
            state_q  <= S_DCMRST;
            cnt_q    <= '0;
            stg_q    <= 2'd0;
            dcmRst_q <= 1'b1;
            rstOut_q <= 3'b111;
          end else if (cnt_q == STG_LAST) begin
            cnt_q           <= '0;
            rstOut_q[stg_q] <= 1'b0;
            if (stg_q == 2'd2) begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
            end else begin
              stg_q <= stg_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (!lockS) begin
            state_q  <= S_DCMRST;
            cnt_q    <= '0;
            stg_q    <= 2'd0;
            dcmRst_q <= 1'b1;
            rstOut_q <= 3'b111;
            ready_q  <= 1'b0;
          end
        end
        S_FAIL: begin
          dcmRst_q  <= 1'b1;
          rstOut_q  <= 3'b111;
          lockErr_q <= 1'b1;
        end
        default: begin
          state_q <= S_DCMRST;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dcmRst   = dcmRst_q;
  assign rstOut   = rstOut_q;
  assign ready    = ready_q;
  assign retryCnt = retry_q;
  assign lockErr  = lockErr_q;

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Clock/reset sequencer for the DCM-based clock generator. Runs on the free-running buffered board clock and drives the DCM `RST` input. It watches the DCM `LOCKED` output, retries the DCM when lock times out, and releases three staged reset outputs in a fixed order once lock is stable. It sits between the board reset/console reset request and every downstream reset consumer. Consumers in the DCM output domain re-synchronize `rstOut` locally.

## Interface

Parameters:
- `RST_CYCLES`, 8: cycles `dcmRst` is held high per DCM reset attempt (≥2).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT for lock before a retry (≥4).
- `STAGE_DELAY`, 16: cycles between successive reset-stage releases (≥1).
- `MAX_RETRY`, 4: failed lock attempts before entering FAIL (1–15).

Ports:
- `clk` in 1: board clock (buffered input clock, not the DCM output).
- `rstN` in 1: reset, asynchronous, active-low.
- `swRst` in 1: synchronous console reset request, level sensitive.
- `dcmLocked` in 1: DCM `LOCKED`, asynchronous; 2-flop synchronized internally.
- `dcmRst` out 1: DCM reset, active-high.
- `rstOut` out 3: staged resets, active-high. Bit 0 releases first, bit 2 last.
- `ready` out 1: high only in RUN (all stages released).
- `retryCnt` out 4: lock timeouts since last `rstN`/`swRst`, saturating at 15.
- `lockErr` out 1: sticky, high in FAIL.

## Operation

- States: DCMRST, WAIT, REL, RUN, FAIL. One shared cycle counter `cnt` and a stage index `stg` (0–2).
- Reset (`rstN`=0): state DCMRST, `cnt`=0, `stg`=0, `dcmRst`=1, `rstOut`=3'b111, `ready`=0, `retryCnt`=0, `lockErr`=0. Both sync flops are cleared.
- `lockS` denotes the synchronized lock signal.
- DCMRST: `dcmRst`=1 and `rstOut`=111. After `RST_CYCLES` cycles, go to WAIT with `cnt`=0.
- WAIT: `dcmRst`=0 and `rstOut`=111.
  - `lockS`=1: go to REL with `cnt`=0 and `stg`=0.
  - `cnt`=`LOCK_TIMEOUT`-1 with `lockS`=0: increment `retryCnt` (saturating). If the new value is ≥ `MAX_RETRY`, go to FAIL; otherwise go to DCMRST with `cnt`=0.
- REL: counts to `STAGE_DELAY`-1, then clears `rstOut[stg]`, increments `stg`, and clears `cnt`. Releasing stage 2 enters RUN. Released bits stay released while in REL.
- RUN: `ready`=1 and `rstOut`=000.
- Lock loss (`lockS`=0 in REL or RUN): on the next edge, `rstOut`=111, `ready`=0, state DCMRST, `cnt`=0. Lock loss does not increment `retryCnt`.
- FAIL: `dcmRst`=1, `rstOut`=111, `lockErr`=1. The block stays here until `rstN` or `swRst`; `dcmLocked` is ignored.
- `swRst`=1 has priority over every state and event except `rstN`. While it is high, the block holds reset values (state DCMRST, `cnt`=0, `retryCnt`=0, `lockErr`=0, `dcmRst`=1, `rstOut`=111). Sequencing starts on the first cycle after it falls.
- If a timeout and lock arrival coincide in WAIT, lock wins (go to REL).

## Timing

- All outputs are registered. There is no combinational path from any input to any output.
- Lock input latency: 2 cycles through the synchronizer, plus 1 cycle for the state change.
- After `rstN` rises: `dcmRst` is high for exactly `RST_CYCLES` edges and falls on edge `RST_CYCLES`.
- With lock already stable when WAIT is entered, count from the first WAIT cycle:
  - REL is entered 1 cycle later.
  - `rstOut[0]` falls `STAGE_DELAY` cycles after REL entry.
  - `rstOut[1]` falls after 2×`STAGE_DELAY`.
  - `rstOut[2]` and `ready` change on the same edge, after 3×`STAGE_DELAY`.
- Lock deassert to `rstOut`=111: 3 cycles (2 sync + 1).
- Timeout retry period: `LOCK_TIMEOUT` + `RST_CYCLES` cycles per attempt.
- `cnt` must be wide enough for max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STAGE_DELAY`).

## Test plan

All scenarios use defaults unless stated.

1. **Normal bring-up.** Release `rstN`; raise `dcmLocked` at cycle 20. Required: `dcmRst` 1→0 at cycle 8; `rstOut` goes 111→110→100→000 at 16-cycle spacing; `ready`=1 together with `rstOut`=000; `retryCnt`=0.
2. **Lock timeout then success.** `LOCK_TIMEOUT`=64; keep `dcmLocked`=0 through the first attempt, then raise it. Required: a second 8-cycle `dcmRst` pulse; `retryCnt`=1; bring-up completes with `lockErr`=0.
3. **Retry exhaustion.** `LOCK_TIMEOUT`=64, `MAX_RETRY`=3, `dcmLocked` held at 0. Required: 3 `dcmRst` pulses, then FAIL with `lockErr`=1, `dcmRst`=1, `retryCnt`=3. Later raising `dcmLocked` has no effect. Pulsing `swRst` clears `lockErr` and `retryCnt` and restarts the sequence.
4. **Lock loss in RUN.** After `ready`=1, drop `dcmLocked` for 1 cycle. Required: 3 cycles later `rstOut`=111 and `ready`=0; a new 8-cycle `dcmRst` pulse follows; `retryCnt` unchanged.
5. **Lock glitch mid-REL.** Drop lock after `rstOut`=110. Required: `rstOut` returns to 111 with no partial release persisting.
6. **Async reset mid-operation.** Assert `rstN`=0 in REL. Required: all outputs take their reset values immediately, without waiting for a clock edge.
